subleq_core: RTL and testbench

- Execution controller for the single-instruction (SUBLEQ) machine.
- Drives both ports of the dual-port word memory directly and consumes its registered read data.
- Each instruction is three consecutive words A, B, C at pc: mem[B] <= mem[B] - mem[A]; if the result is <= 0 (signed), pc <= C, else pc <= pc + 3.
- Multi-cycle, non-pipelined: 5 cycles per instruction.

---
 rtl/subleq_core.sv | 118 +++++++++++
 tb/tb_subleq_core.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_core.sv
// SUBLEQ execution controller: runs A,B,C instructions in a 5-cycle sequence
// over a dual-port memory that returns registered read data.
package gc;
  localparam int WORD_SIZE = 16;
endpackage

module subleq_core #(
  parameter int                   WORD_SIZE = gc::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter logic [WORD_SIZE-1:0] HALT_ADDR = {WORD_SIZE{1'b1}},
  parameter int                   CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [WORD_SIZE-1:0] add1,
  output logic [WORD_SIZE-1:0] dataIn1,
  output logic                 write1,
  input  logic [WORD_SIZE-1:0] dataOut1,
  output logic [WORD_SIZE-1:0] add2,
  output logic [WORD_SIZE-1:0] dataIn2,
  output logic                 write2,
  input  logic [WORD_SIZE-1:0] dataOut2,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] pc,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH_AB = 3'd1;
  localparam logic [2:0] FETCH_C  = 3'd2;
  localparam logic [2:0] READ_OP  = 3'd3;
  localparam logic [2:0] EXEC     = 3'd4;
  localparam logic [2:0] WRITE    = 3'd5;
  localparam logic [2:0] HALT     = 3'd6;

  logic [2:0]           state;
  logic [WORD_SIZE-1:0] a, b, c, res;
  logic [WORD_SIZE-1:0] pc_plus1, pc_plus2, pc_plus3;
  logic                 taken;

  assign pc_plus1 = pc + WORD_SIZE'(1);
  assign pc_plus2 = pc + WORD_SIZE'(2);
  assign pc_plus3 = pc + WORD_SIZE'(3);
  assign taken    = res[WORD_SIZE-1] | (res == '0);

  // Port drive depends on state and registers only, never on read data.
  always_comb begin
    add1    = '0;
    add2    = '0;
    dataIn1 = '0;
    dataIn2 = '0;
    write1  = 1'b0;
    write2  = 1'b0;
    case (state)
      FETCH_AB: begin
        add1 = pc;
        add2 = pc_plus1;
      end
      FETCH_C: add1 = pc_plus2;
      READ_OP: begin
        add1 = a;
        add2 = b;
      end
      WRITE: begin
        add2    = b;
        dataIn2 = res;
        write2  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      instr_count <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      res         <= '0;
    end else begin
      case (state)
        IDLE: if (run) state <= FETCH_AB;
        FETCH_AB: state <= FETCH_C;
        FETCH_C: begin
          a     <= dataOut1;
          b     <= dataOut2;
          state <= READ_OP;
        end
        READ_OP: begin
          c     <= dataOut1;
          state <= EXEC;
        end
        EXEC: begin
          res   <= dataOut2 - dataOut1;
          state <= WRITE;
        end
        WRITE: begin
          pc <= taken ? c : pc_plus3;
          if (instr_count != {CNT_WIDTH{1'b1}})
            instr_count <= instr_count + CNT_WIDTH'(1);
          if (taken && (c == HALT_ADDR)) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            state <= run ? FETCH_AB : IDLE;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_core.sv
// Scoreboard bench for subleq_core: a behavioural dual-port memory plus
// per-scenario tasks comparing observed port-2 writes against expectations.
module tb_subleq_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] add1, dataIn1, dataOut1, add2, dataIn2, dataOut2, pc;
  logic        write1, write2, halted;
  logic [31:0] instr_count;

  logic        tb_we;
  logic [15:0] tb_addr, tb_data;
  logic [15:0] mem [0:65535];

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          w1_seen = 0;
  int          checks = 0;
  int          failures = 0;

  subleq_core dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .add1(add1), .dataIn1(dataIn1), .write1(write1), .dataOut1(dataOut1),
    .add2(add2), .dataIn2(dataIn2), .write2(write2), .dataOut2(dataOut2),
    .halted(halted), .pc(pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Registered-read memory; a writing port does not refresh its read data.
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (write2) mem[add2] <= dataIn2;
    if (!write1) dataOut1 <= mem[add1];
    if (!write2) dataOut2 <= mem[add2];
  end

  always @(negedge clk) begin
    if (write2) obs_q.push_back({add2, dataIn2});
    if (write1) w1_seen++;
  end

  task automatic load_word(input logic [15:0] addr, input logic [15:0] val);
    tb_we   = 1'b1;
    tb_addr = addr;
    tb_data = val;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic load_instr(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    load_word(16'd0, x);
    load_word(16'd1, y);
    load_word(16'd2, z);
  endtask

  task automatic apply_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_write(input int limit, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (write2) found = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({write1, write2, halted, add1, add2, pc} !== 35'd0 || instr_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_values got w1=%b w2=%b h=%b a1=%h a2=%h pc=%h cnt=%0d expected all zero",
               write1, write2, halted, add1, add2, pc, instr_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    w1_seen = 0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0 || w1_seen != 0 || pc !== 16'd0 || instr_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_idle got writes=%0d w1=%0d pc=%h cnt=%0d expected 0 0 0000 0",
               obs_q.size(), w1_seen, pc, instr_count);
    end
  endtask

  task automatic test_not_taken();
    bit found;
    int cycles;
    logic [31:0] e, o;
    apply_reset();
    load_instr(16'd6, 16'd7, 16'd9);
    load_word(16'd6, 16'd2);
    load_word(16'd7, 16'd5);
    exp_q.push_back({16'd7, 16'd3});
    run = 1'b1;
    wait_write(20, found, cycles);
    run = 1'b0;
    checks++;
    if (!found || cycles != 5) begin
      failures++;
      $display("[TB] FAIL not_taken_latency got found=%b cycle=%0d expected 1 5", found, cycles);
    end
    repeat (6) @(negedge clk);
    e = exp_q.pop_front();
    o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
    checks++;
    if (o !== e || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL not_taken_write got %h (extra=%0d) expected %h", o, obs_q.size(), e);
    end
    checks++;
    if (pc !== 16'd3 || instr_count !== 32'd1 || mem[7] !== 16'd3) begin
      failures++;
      $display("[TB] FAIL not_taken_state got pc=%h cnt=%0d mem7=%h expected 0003 1 0003", pc, instr_count, mem[7]);
    end
  endtask

  task automatic test_taken_equal();
    bit found;
    int cycles;
    logic [31:0] e, o;
    apply_reset();
    load_instr(16'd6, 16'd6, 16'd12);
    load_word(16'd6, 16'd5);
    exp_q.push_back({16'd6, 16'd0});
    run = 1'b1;
    wait_write(20, found, cycles);
    run = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
    checks++;
    if (!found || o !== e) begin
      failures++;
      $display("[TB] FAIL equal_write got %h found=%b expected %h", o, found, e);
    end
    checks++;
    if (pc !== 16'd12 || mem[6] !== 16'd0) begin
      failures++;
      $display("[TB] FAIL equal_branch got pc=%h mem6=%h expected 000c 0000", pc, mem[6]);
    end
  endtask

  task automatic test_negative_wrap();
    bit found;
    int cycles;
    logic [31:0] e, o;
    apply_reset();
    load_instr(16'd6, 16'd7, 16'd20);
    load_word(16'd6, 16'd1);
    load_word(16'd7, 16'd0);
    exp_q.push_back({16'd7, 16'hFFFF});
    run = 1'b1;
    wait_write(20, found, cycles);
    run = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
    checks++;
    if (!found || o !== e) begin
      failures++;
      $display("[TB] FAIL wrap_write got %h found=%b expected %h", o, found, e);
    end
    checks++;
    if (pc !== 16'd20) begin
      failures++;
      $display("[TB] FAIL wrap_branch got pc=%h expected 0014", pc);
    end
  endtask

  task automatic test_halt();
    bit found;
    int cycles, changes;
    logic [15:0] a1, a2;
    logic [31:0] e, o;
    apply_reset();
    load_instr(16'd6, 16'd7, 16'hFFFF);
    load_word(16'd6, 16'd1);
    load_word(16'd7, 16'd0);
    exp_q.push_back({16'd7, 16'hFFFF});
    run = 1'b1;
    wait_write(20, found, cycles);
    @(negedge clk);
    #1;
    checks++;
    if (!found || halted !== 1'b1 || pc !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL halt_entry got found=%b halted=%b pc=%h expected 1 1 ffff", found, halted, pc);
    end
    a1 = add1;
    a2 = add2;
    changes = 0;
    repeat (20) begin
      @(negedge clk);
      if (write1 || write2 || add1 !== a1 || add2 !== a2) changes++;
    end
    checks++;
    if (changes != 0 || halted !== 1'b1 || instr_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL halt_hold got changes=%0d halted=%b cnt=%0d expected 0 1 1", changes, halted, instr_count);
    end
    e = exp_q.pop_front();
    o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
    checks++;
    if (o !== e || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL halt_write got %h (extra=%0d) expected %h", o, obs_q.size(), e);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    int cycles;
    logic [31:0] e, o;
    apply_reset();
    load_instr(16'd6, 16'd7, 16'd9);
    load_word(16'd6, 16'd2);
    load_word(16'd7, 16'd5);
    run = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (write2 !== 1'b0 || add2 !== 16'd0 || add1 !== 16'd0 || pc !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got w2=%b a1=%h a2=%h pc=%h expected 0 0000 0000 0000",
               write2, add1, add2, pc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || mem[7] !== 16'd5) begin
      failures++;
      $display("[TB] FAIL midreset_abandon got writes=%0d mem7=%h expected 0 0005", obs_q.size(), mem[7]);
    end
    exp_q.push_back({16'd7, 16'd3});
    rst_n = 1'b1;
    wait_write(20, found, cycles);
    run = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
    checks++;
    if (!found || cycles != 5 || o !== e) begin
      failures++;
      $display("[TB] FAIL midreset_restart got %h cycle=%0d expected %h 5", o, cycles, e);
    end
    checks++;
    if (pc !== 16'd3 || mem[7] !== 16'd3 || instr_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL midreset_state got pc=%h mem7=%h cnt=%0d expected 0003 0003 1", pc, mem[7], instr_count);
    end
  endtask

  // First instruction rewrites the B word of the second one.
  task automatic test_back_to_back();
    bit found1, found2;
    int c1, c2;
    logic [31:0] e, o;
    apply_reset();
    load_instr(16'd9, 16'd4, 16'd3);
    load_word(16'd3, 16'd10);
    load_word(16'd4, 16'd10);
    load_word(16'd5, 16'd30);
    load_word(16'd9, 16'd1);
    load_word(16'd10, 16'd5);
    exp_q.push_back({16'd4, 16'd9});
    exp_q.push_back({16'd9, 16'hFFFC});
    run = 1'b1;
    wait_write(20, found1, c1);
    wait_write(20, found2, c2);
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (!found1 || !found2 || c2 != 5) begin
      failures++;
      $display("[TB] FAIL b2b_spacing got found=%b%b gap=%0d expected 11 5", found1, found2, c2);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_DEAD;
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL b2b_write%0d got %h expected %h", i, o, e);
      end
    end
    checks++;
    if (pc !== 16'd30 || instr_count !== 32'd2 || mem[10] !== 16'd5) begin
      failures++;
      $display("[TB] FAIL b2b_state got pc=%h cnt=%0d mem10=%h expected 001e 2 0005", pc, instr_count, mem[10]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    run     = 1'b0;
    tb_we   = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    @(negedge clk);
    test_reset();
    test_not_taken();
    test_taken_equal();
    test_negative_wrap();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
